// File: rtl/secuenciador_eje04_if.sv
// Bundle between the eje04 stimulus sequencer and its surroundings:
// control requests, FSM observation inputs, drive outputs and status.
interface secuenciador_eje04_if;
   logic       arranque;
   logic       cancelar;
   logic       A;
   logic       L;
   logic       Y;
   logic       B;
   logic       inicio;
   logic       falsa;
   logic       reset_fsm;
   logic [2:0] paso;
   logic       ocupado;
   logic       listo;
   logic [7:0] firma;

   modport slave (
      input  arranque, cancelar, A, L, Y, B,
      output inicio, falsa, reset_fsm, paso, ocupado, listo, firma
   );

   modport master (
      output arranque, cancelar, A, L, Y, B,
      input  inicio, falsa, reset_fsm, paso, ocupado, listo, firma
   );
endinterface

// File: rtl/secuenciador_eje04.sv
// Drives eje04 through a fixed 8-step stimulus table and folds A/L/Y/B into a signature.
// Latency: drive outputs are registered, one edge after the decision; no backpressure.
module secuenciador_eje04 #(
   parameter int ANCHO_CNT = 4
) (
   input logic                 clk,
   input logic                 reset,
   secuenciador_eje04_if.slave bus
);

   typedef enum logic [1:0] {REPOSO, EJECUTA, FIN} estado_t;

   estado_t              estado_q, estado_d;
   logic [2:0]           paso_q, paso_d;
   logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
   logic [7:0]           firma_q, firma_d;
   logic [2:0]           drv_q, drv_d;   // {reset_fsm, inicio, falsa}
   logic                 fin_paso;

   function automatic logic [2:0] fila(input logic [2:0] p);
      case (p)
         3'd0:    fila = 3'b100;
         3'd2:    fila = 3'b010;
         3'd3:    fila = 3'b001;
         3'd4:    fila = 3'b001;
         3'd5:    fila = 3'b011;
         3'd6:    fila = 3'b001;
         default: fila = 3'b000;
      endcase
   endfunction

   // Counter reload is dwell-1: every step lasts 2 cycles except the last (3).
   function automatic logic [ANCHO_CNT-1:0] recarga(input logic [2:0] p);
      recarga = (p == 3'd7) ? ANCHO_CNT'(2) : ANCHO_CNT'(1);
   endfunction

   assign fin_paso = (estado_q == EJECUTA) && (cnt_q == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q <= REPOSO;
         paso_q   <= '0;
         cnt_q    <= '0;
         firma_q  <= '0;
         drv_q    <= '0;
      end else begin
         estado_q <= estado_d;
         paso_q   <= paso_d;
         cnt_q    <= cnt_d;
         firma_q  <= firma_d;
         drv_q    <= drv_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      if (bus.cancelar) begin
         estado_d = REPOSO;
      end else begin
         unique case (estado_q)
            REPOSO, FIN: if (bus.arranque) estado_d = EJECUTA;
            EJECUTA:     if (fin_paso && paso_q == 3'd7) estado_d = FIN;
            default:     estado_d = REPOSO;
         endcase
      end
   end

   always_comb begin
      paso_d  = paso_q;
      cnt_d   = cnt_q;
      firma_d = firma_q;
      if (bus.cancelar) begin
         paso_d = '0;
         cnt_d  = '0;
      end else if (estado_q != EJECUTA && bus.arranque) begin
         paso_d  = '0;
         cnt_d   = recarga(3'd0);
         firma_d = '0;
      end else if (estado_q == EJECUTA) begin
         if (fin_paso) begin
            firma_d = {firma_q[3:0], firma_q[7:4]} ^ {4'b0000, bus.A, bus.L, bus.Y, bus.B};
            if (paso_q != 3'd7) begin
               paso_d = paso_q + 3'd1;
               cnt_d  = recarga(paso_q + 3'd1);
            end
         end else begin
            cnt_d = cnt_q - ANCHO_CNT'(1);
         end
      end
      // Drives follow the row of the step that will be active after this edge.
      drv_d = (estado_d == EJECUTA) ? fila(paso_d) : 3'b000;
   end

   assign bus.reset_fsm = drv_q[2];
   assign bus.inicio    = drv_q[1];
   assign bus.falsa     = drv_q[0];
   assign bus.paso      = paso_q;
   assign bus.firma     = firma_q;
   assign bus.ocupado   = (estado_q == EJECUTA);
   assign bus.listo     = (estado_q == FIN);

endmodule
